// File: rtl/pipeline_credit_output_buffer.sv
// Credit-managed output buffer for a valid-only pipeline.
//
// Upstream may launch into the pipeline only when a credit is available; each
// launch reserves one FIFO entry, so the pipeline result always has somewhere
// to land even though the pipeline itself cannot be stalled. The credit is
// returned when the downstream consumer pops the entry.
//
// Handshakes: issue fires when issue_valid && issue_ready; pop fires when
// out_valid && out_ready. issue_ready and out_valid are decoded from
// registered state only, so neither depends combinationally on any input.
// A ready seen without its matching valid (or vice versa) changes nothing.
module pipeline_credit_output_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       pipe_valid,
    input  logic [WIDTH-1:0]           pipe_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] credits,
    output logic                       overflow_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    credits_q;
    logic             ovf_q;

    logic issue_fire;
    logic pop;
    logic full;
    logic push;
    logic drop;

    // Handshake and write-acceptance decode.
    always_comb begin
        issue_fire = issue_valid && (credits_q != '0);
        pop        = (count_q != '0) && out_ready;
        full       = (count_q == DEPTH_C);
        // A full FIFO still accepts a write when the head leaves this cycle.
        push       = pipe_valid && (!full || pop);
        drop       = pipe_valid && full && !pop;
    end

    assign issue_ready  = (credits_q != '0);
    assign out_valid    = (count_q != '0);
    assign out_data     = mem[rd_ptr];
    assign credits      = credits_q;
    assign overflow_err = ovf_q;

    // Credit counter: launches take a credit, pops give one back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= DEPTH_C;
        end else if (issue_fire && !pop) begin
            credits_q <= credits_q - ONE_C;
        end else if (pop && !issue_fire && (credits_q != DEPTH_C)) begin
            credits_q <= credits_q + ONE_C;
        end
    end

    // Occupancy and pointers; simultaneous push and pop advance both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PONE_C;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PONE_C;
            end
            if (push && !pop) begin
                count_q <= count_q + ONE_C;
            end else if (pop && !push) begin
                count_q <= count_q - ONE_C;
            end
        end
    end

    // Storage is deliberately left un-reset; out_data is ignored while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pipe_data;
        end
    end

    // Sticky flag for a pipeline result arriving with nowhere to go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_credit_output_buffer.sv
// Bench for pipeline_credit_output_buffer: directed scenarios followed by a
// randomized run through a bench-side fixed-latency pipeline, all checked
// against a queue-based reference model.
module tb_pipeline_credit_output_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LAT   = 3;

    // Clock/reset and DUT signals
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic             pipe_valid = 1'b0;
    logic [WIDTH-1:0] pipe_data = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    credits;
    logic             overflow_err;

    always #5 clk = ~clk;

    pipeline_credit_output_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .pipe_valid   (pipe_valid),
        .pipe_data    (pipe_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .credits      (credits),
        .overflow_err (overflow_err)
    );

    // Scoreboard / reference model state
    int               vectors = 0;
    int               miscompares = 0;
    int               m_credits;
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf;
    logic             m_fire;
    logic [WIDTH:0]   dl[$];
    logic [WIDTH-1:0] fill_vals[4];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credits = DEPTH;
        exp_q.delete();
        m_ovf = 1'b0;
    endtask

    // One clock edge of the buffer's rules, applied to the held inputs.
    task automatic model_step();
        logic pop;
        logic push;
        m_fire = issue_valid && (m_credits != 0);
        pop    = (exp_q.size() != 0) && out_ready;
        push   = pipe_valid && ((exp_q.size() < DEPTH) || pop);
        if (pipe_valid && !push) m_ovf = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(pipe_data);
        if (pop && !m_fire && m_credits < DEPTH) m_credits++;
        else if (m_fire && !pop) m_credits--;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".credits"}, WIDTH'(credits), WIDTH'(m_credits));
        chk({tag, ".issue_ready"}, WIDTH'(issue_ready), WIDTH'(m_credits != 0));
        chk({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(exp_q.size() != 0));
        chk({tag, ".overflow_err"}, WIDTH'(overflow_err), WIDTH'(m_ovf));
        if (exp_q.size() != 0) chk({tag, ".out_data"}, out_data, exp_q[0]);
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic iv, input logic pv, input logic [WIDTH-1:0] pd, input logic ordy);
        issue_valid = iv;
        pipe_valid  = pv;
        pipe_data   = pd;
        out_ready   = ordy;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    initial begin
        // Reset held, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_hold");
        #10 rst = 1'b0;
        #1;
        check_all("rst_release");
        chk("rst_release.credits4", WIDTH'(credits), 32'd4);

        // Four back-to-back launches, then a fifth that must not be granted
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            cycle("issue");
            chk("issue.credits_step", WIDTH'(credits), WIDTH'(3 - i));
        end
        chk("issue.ready_low", WIDTH'(issue_ready), 32'd0);
        drive(1'b1, 1'b0, '0, 1'b0);
        cycle("issue5");
        chk("issue5.credits0", WIDTH'(credits), 32'd0);

        // Pipeline results arrive
        fill_vals[0] = 32'h11; fill_vals[1] = 32'h22;
        fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, fill_vals[i], 1'b0);
            cycle("fill");
        end
        chk("fill.head", out_data, 32'h11);

        // Unsolicited result into a full buffer: dropped, flag set
        drive(1'b0, 1'b1, 32'h55, 1'b0);
        cycle("ovf");
        chk("ovf.flag", WIDTH'(overflow_err), 32'd1);
        chk("ovf.head", out_data, 32'h11);

        // Drain on consecutive edges
        for (int i = 0; i < 4; i++) begin
            chk("drain.head", out_data, fill_vals[i]);
            drive(1'b0, 1'b0, '0, 1'b1);
            cycle("drain");
        end
        chk("drain.empty", WIDTH'(out_valid), 32'd0);
        chk("drain.credits4", WIDTH'(credits), 32'd4);
        chk("drain.ovf_sticky", WIDTH'(overflow_err), 32'd1);

        // Simultaneous launch and pop at credits = 2, across the pointer wrap
        drive(1'b1, 1'b0, '0, 1'b0); cycle("sim.issue");
        drive(1'b1, 1'b0, '0, 1'b0); cycle("sim.issue");
        drive(1'b0, 1'b1, 32'hC1, 1'b0); cycle("sim.fill");
        drive(1'b0, 1'b1, 32'hC2, 1'b0); cycle("sim.fill");
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, WIDTH'(32'hC3 + i), 1'b1);
            cycle("sim.both");
            chk("sim.credits2", WIDTH'(credits), 32'd2);
        end
        drive(1'b0, 1'b0, '0, 1'b1); cycle("sim.drain");
        drive(1'b0, 1'b0, '0, 1'b1); cycle("sim.drain");

        // Asynchronous reset between edges with count = 2, credits = 1
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            cycle("ar.issue");
        end
        drive(1'b0, 1'b1, 32'hD1, 1'b0); cycle("ar.fill");
        drive(1'b0, 1'b1, 32'hD2, 1'b0); cycle("ar.fill");
        chk("ar.credits1", WIDTH'(credits), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("ar.out_valid", WIDTH'(out_valid), 32'd0);
        chk("ar.credits", WIDTH'(credits), 32'd4);
        chk("ar.issue_ready", WIDTH'(issue_ready), 32'd1);
        chk("ar.ovf_cleared", WIDTH'(overflow_err), 32'd0);
        #2 rst = 1'b0;

        // Randomized run through a fixed-latency valid-only pipeline
        dl.delete();
        for (int i = 0; i < LAT; i++) dl.push_back('0);
        for (int i = 0; i < 400; i++) begin
            pipe_valid  = dl[0][WIDTH];
            pipe_data   = dl[0][WIDTH-1:0];
            issue_valid = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 9) < ((i < 200) ? 3 : 8));
            cycle("rand");
            void'(dl.pop_front());
            dl.push_back({m_fire, WIDTH'($urandom)});
        end
        chk("rand.no_ovf", WIDTH'(overflow_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
